// File: rtl/sccpu_pkg.sv
// Shared definitions for the single-cycle CPU fetch stage.
// The ERR state exists only when PC_ALIGN_CHECK_EN is defined.
package sccpu_pkg;

  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;

  typedef enum logic [1:0] {
    PCS_SEQ = 2'b00,
    PCS_BR  = 2'b01,
    PCS_JR  = 2'b10,
    PCS_J   = 2'b11
  } pcsource_e;

  // One bit per active output, so imem_req/inst_valid are plain register bits.
  typedef enum logic [2:0] {
    IDLE  = 3'b000,
    FETCH = 3'b001,
`ifdef PC_ALIGN_CHECK_EN
    HOLD  = 3'b010,
    ERR   = 3'b100
`else
    HOLD  = 3'b010
`endif
  } state_e;

  function automatic logic [31:0] br_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/sccpu_fetch_if.sv
// Control, instruction-memory and decoder signals of the fetch stage.
// master = fetch stage, slave = its environment (control, memory, decoder).
interface sccpu_fetch_if;
  logic [1:0]  pcsource;
  logic [31:0] rpc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        dec_ready;
  logic [31:0] inst;
  logic        inst_valid;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic        misalign;

  modport master (
    input  pcsource, rpc, imem_ack, imem_rdata, dec_ready,
    output imem_req, imem_addr, inst, inst_valid, pc, pc4, misalign
  );

  modport slave (
    output pcsource, rpc, imem_ack, imem_rdata, dec_ready,
    input  imem_req, imem_addr, inst, inst_valid, pc, pc4, misalign
  );
endinterface

// File: rtl/sccpu_npc.sv
// Purely combinational next-PC selection: sequential, branch, register, jump.
module sccpu_npc
  import sccpu_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [25:0] inst_lo,
  input  logic [1:0]  pcsource,
  input  logic [31:0] rpc,
  output logic [31:0] pc4,
  output logic [31:0] npc
);

  assign pc4 = pc + 32'd4;

  always_comb begin
    // NOTE: default first so every path assigns npc and no latch is inferred.
    npc = pc4;
    case (pcsource)
      PCS_SEQ: npc = pc4;
      PCS_BR:  npc = pc4 + br_offset(inst_lo[15:0]);
      PCS_JR:  npc = rpc;
      PCS_J:   npc = {pc4[31:28], inst_lo, 2'b00};
      default: npc = pc4;
    endcase
  end

endmodule

// File: rtl/sccpu_fetch.sv
// Fetch stage: requests pc from instruction memory and holds the word for the decoder.
// Define PC_ALIGN_CHECK_EN to trap misaligned targets in ERR instead of truncating them.
module sccpu_fetch
  import sccpu_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  sccpu_fetch_if.master bus
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] npc;
  logic [31:0] pc4;

  sccpu_npc u_npc (
    .pc       (pc_q),
    .inst_lo  (inst_q[25:0]),
    .pcsource (bus.pcsource),
    .rpc      (bus.rpc),
    .pc4      (pc4),
    .npc      (npc)
  );

`ifdef PC_ALIGN_CHECK_EN
  logic misalign_q, misalign_d;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
`ifdef PC_ALIGN_CHECK_EN
    misalign_d = misalign_q;
`endif
    case (state_q)
      IDLE:  state_d = FETCH;
      FETCH: begin
        if (bus.imem_ack) begin
          inst_d  = bus.imem_rdata;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (bus.dec_ready) begin
`ifdef PC_ALIGN_CHECK_EN
          if (npc[1:0] != 2'b00) begin
            misalign_d = 1'b1;
            state_d    = ERR;
          end else begin
            pc_d    = npc;
            state_d = FETCH;
          end
`else
          pc_d    = npc & 32'hFFFF_FFFC;
          state_d = FETCH;
`endif
        end
      end
`ifdef PC_ALIGN_CHECK_EN
      ERR:     state_d = ERR;
`endif
      default: state_d = IDLE;
    endcase
  end

  // NOTE: async reset clears every flop; inst is a plain register, not a memory.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_VECTOR;
      inst_q  <= '0;
    end else begin
      // NOTE: non-blocking so all state updates see pre-edge values.
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) misalign_q <= 1'b0;
    else       misalign_q <= misalign_d;
  end
  assign bus.misalign = misalign_q;
`else
  assign bus.misalign = 1'b0;
`endif

  // Outputs are single state bits: no decode logic, no input-to-output path.
  assign bus.imem_req   = state_q[0];
  assign bus.inst_valid = state_q[1];
  assign bus.imem_addr  = pc_q;
  assign bus.pc         = pc_q;
  assign bus.pc4        = pc4;
  assign bus.inst       = inst_q;

endmodule
